uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO in front of an 8N1 UART transmitter.
// A byte is popped into the shifter when the line is idle, or at the end of
// the stop bit so that queued frames go out back-to-back.
module uart_tx_buf #(
    parameter int unsigned CLK_PER_HALF_BIT = 434,
    parameter int unsigned DEPTH            = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               wdata,
    input  logic                     wvalid,
    output logic                     wready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned TMR_W   = $clog2(BIT_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic             push_c;
    logic             pop_c;
    logic             tmr_end_c;
    logic [2:0]       idx_nxt_c;

    assign wready   = (count_q < CNT_W'(DEPTH));
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign txd      = txd_q;
    assign count    = count_q;
    assign overflow = ovf_q;

    // Next-state logic: frame sequencing, FIFO pointers, occupancy and overflow
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_d     = mem_q;
        pop_c     = 1'b0;
        push_c    = wvalid && wready;
        tmr_end_c = (tmr_q == TMR_W'(BIT_CYC - 1));
        idx_nxt_c = idx_q + 3'd1;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop_c = 1'b1;
                end
            end
            S_START: begin
                if (tmr_end_c) begin
                    tmr_d   = '0;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DATA: begin
                if (tmr_end_c) begin
                    tmr_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_nxt_c;
                        txd_d = shift_q[idx_nxt_c];
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_STOP: begin
                if (tmr_end_c) begin
                    tmr_d = '0;
                    if (count_q != '0) begin
                        pop_c = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Loading the shifter starts a new frame with its start bit
        if (pop_c) begin
            shift_d = mem_q[rptr_q];
            rptr_d  = rptr_q + PTR_W'(1);
            tmr_d   = '0;
            idx_d   = 3'd0;
            txd_d   = 1'b0;
            state_d = S_START;
        end

        if (push_c) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wvalid && !wready) begin
            ovf_d = 1'b1;
        end
    end

    // Control and line registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Testbench for uart_tx_buf: timeline reference model plus 8N1 decoder scoreboard.
module tb_uart_tx_buf;

    localparam int CPH   = 4;
    localparam int DEPTH = 8;
    localparam int BITC  = 2 * CPH;
    localparam int FRAME = 10 * BITC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic       txd;
    logic       busy;
    logic [3:0] count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_buf #(.CLK_PER_HALF_BIT(CPH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .txd(txd), .busy(busy), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: bytes waiting, and the time line of the frame being sent.
    // A frame occupies FRAME edges from the edge that pops it; a pop happens on
    // any edge where bytes are waiting and the previous frame has finished.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         edge_n;
    int         frame_start;
    logic [7:0] cur_byte;
    logic       m_ovf;
    bit         m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            edge_n      = 0;
            frame_start = -1000;
            cur_byte    = 8'h00;
            m_ovf       = 1'b0;
        end else begin
            m_acc = wvalid && (mq.size() < DEPTH);
            if (wvalid && !m_acc) m_ovf = 1'b1;
            if (mq.size() > 0 && edge_n >= frame_start + FRAME) begin
                cur_byte    = mq.pop_front();
                frame_start = edge_n;
            end
            if (m_acc) begin
                mq.push_back(wdata);
                exp_q.push_back(wdata);
            end
            edge_n++;
        end
    end

    function automatic logic exp_txd();
        int off;
        int b;
        off = (edge_n - 1) - frame_start;
        if (off < 0 || off >= FRAME) return 1'b1;
        b = off / BITC;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur_byte[b-1];
    endfunction

    function automatic logic exp_busy();
        int off;
        off = (edge_n - 1) - frame_start;
        return ((off >= 0) && (off < FRAME)) || (mq.size() > 0);
    endfunction

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("txd", 32'(txd), 32'(exp_txd()));
            chk("busy", 32'(busy), 32'(exp_busy()));
            chk("wready", 32'(wready), 32'(mq.size() < DEPTH));
            chk("count", 32'(count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // 8N1 decoder: samples mid-bit and pops the scoreboard on each frame
    bit         d_act = 0;
    int         d_off;
    logic [7:0] d_byte;

    always @(negedge clk) begin
        if (rst) begin
            d_act = 0;
        end else if (!d_act) begin
            if (txd == 1'b0) begin
                d_act = 1;
                d_off = 0;
            end
        end else begin
            d_off++;
            if (d_off == BITC / 2) begin
                chk("rx_start_bit", 32'(txd), 32'd0);
            end else if (d_off >= BITC + BITC / 2 && d_off <= 8 * BITC + BITC / 2
                         && ((d_off - BITC / 2) % BITC) == 0) begin
                d_byte[(d_off - BITC - BITC / 2) / BITC] = txd;
            end else if (d_off == 9 * BITC + BITC / 2) begin
                chk("rx_stop_bit", 32'(txd), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected_frame", 32'(d_byte), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_byte", 32'(d_byte), 32'(exp_q.pop_front()));
                end
                d_act = 0;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        wvalid = 1'b1;
        wdata  = b;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        wvalid = 1'b0;
        wdata  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wready", 32'(wready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Idle stability
        repeat (1000) @(negedge clk);
        chk("idle_txd", 32'(txd), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single byte 0xA5
        push(8'hA5);
        chk("a5_before_start", 32'(txd), 32'd1);
        @(negedge clk);
        chk("a5_start_bit", 32'(txd), 32'd0);
        repeat (79) @(negedge clk);
        chk("a5_stop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("a5_done_busy", 32'(busy), 32'd0);
        wait_idle(10);

        // Back-to-back frames
        push(8'h00);
        push(8'hFF);
        wait_idle(3 * FRAME);

        // Overflow: ten pushes on consecutive edges
        for (int i = 0; i < 10; i++) begin
            wvalid = 1'b1;
            wdata  = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 1) chk("ovf_count_edge1", 32'(count), 32'd1);
            if (i == 8) begin
                chk("ovf_count_edge8", 32'(count), 32'd8);
                chk("ovf_wready_edge9", 32'(wready), 32'd0);
            end
        end
        wvalid = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count_after", 32'(count), 32'd8);
        wait_idle(10 * FRAME);

        // Pointer wrap: twenty distinct bytes paced on wready
        for (int i = 0; i < 20; i++) begin
            int guard;
            guard = 0;
            while (!wready && guard < 2 * FRAME) begin
                @(negedge clk);
                guard++;
            end
            chk("wrap_wready_timeout", 32'(wready), 32'd1);
            push(8'(8'h31 + 7 * i));
        end
        wait_idle(25 * FRAME);

        // Reset in the middle of data bit 3 with three bytes queued
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        repeat (32) @(negedge clk);
        chk("mid_in_frame_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_txd", 32'(txd), 32'd1);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) begin
                chk("post_rst_txd", 32'(txd), 32'd1);
                chk("post_rst_busy", 32'(busy), 32'd0);
            end
        end
        chk("post_rst_final_txd", 32'(txd), 32'd1);

        // Randomized traffic with occasional bursts past capacity
        for (int i = 0; i < 3000; i++) begin
            wvalid = ($urandom_range(0, (i < 1500) ? 30 : 90) == 0);
            wdata  = 8'($urandom);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wait_idle((DEPTH + 2) * FRAME);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
